// File: rtl/vga_rom_arbiter_if.sv
// ---------------------------------------------------------------------------
// vga_rom_arbiter_if
//
// Purpose: groups the video-timing, host-read, ROM and pixel signals of the
// VGA ROM arbiter into one bundle. The clock and reset stay outside as plain
// ports.
//
// Modports:
//   slave  - the arbiter side. It receives the video timing, host request
//            and ROM data, and drives the ack, the ROM strobe/address and
//            the returned data.
//   master - the surrounding system: the video timing generator, the host,
//            the ROM model and the colour output.
//
// Signals:
//   enable_horizontal / enable_vertical : active-video window
//   frame_start                         : one-cycle start-of-frame pulse
//   host_req / host_addr / host_ack     : host read request handshake
//   host_rdata / host_rvalid            : host read return
//   rom_en / rom_addr / rom_data        : single-port ROM access
//   pix_data / pix_valid                : pixel stream to the colour output
//   host_stall_cycles                   : present only with ROM_ARB_STATS_EN
//
// Optional feature macro: ROM_ARB_STATS_EN
// ---------------------------------------------------------------------------
interface vga_rom_arbiter_if #(
  parameter int addrSize  = 16,
  parameter int dataWidth = 12
);
  logic                 enable_horizontal;
  logic                 enable_vertical;
  logic                 frame_start;
  logic                 host_req;
  logic [addrSize-1:0]  host_addr;
  logic                 host_ack;
  logic [dataWidth-1:0] host_rdata;
  logic                 host_rvalid;
  logic                 rom_en;
  logic [addrSize-1:0]  rom_addr;
  logic [dataWidth-1:0] rom_data;
  logic [dataWidth-1:0] pix_data;
  logic                 pix_valid;
`ifdef ROM_ARB_STATS_EN
  logic [15:0]          host_stall_cycles;
`endif

`ifdef ROM_ARB_STATS_EN
  modport slave (
    input  enable_horizontal, enable_vertical, frame_start,
    input  host_req, host_addr, rom_data,
    output host_ack, host_rdata, host_rvalid,
    output rom_en, rom_addr, pix_data, pix_valid,
    output host_stall_cycles
  );

  modport master (
    output enable_horizontal, enable_vertical, frame_start,
    output host_req, host_addr, rom_data,
    input  host_ack, host_rdata, host_rvalid,
    input  rom_en, rom_addr, pix_data, pix_valid,
    input  host_stall_cycles
  );
`else
  modport slave (
    input  enable_horizontal, enable_vertical, frame_start,
    input  host_req, host_addr, rom_data,
    output host_ack, host_rdata, host_rvalid,
    output rom_en, rom_addr, pix_data, pix_valid
  );

  modport master (
    output enable_horizontal, enable_vertical, frame_start,
    output host_req, host_addr, rom_data,
    input  host_ack, host_rdata, host_rvalid,
    input  rom_en, rom_addr, pix_data, pix_valid
  );
`endif

endinterface

// File: rtl/vga_rom_arbiter.sv
// ---------------------------------------------------------------------------
// vga_rom_arbiter
//
// Purpose: shares one single-port image ROM between the VGA pixel fetch path
// and a host read port. Display fetches always win during active video. Host
// reads are serviced only in blanking or other idle cycles, with at most one
// host read in flight. Every issued read carries a tag through a pipeline
// that is ROM_LATENCY+1 deep, so that the returned word is steered to the
// pixel output or to the host output.
//
// Parameters:
//   addrSize     ROM address width
//   dataWidth    ROM word width (RGB444)
//   IMAGE_WORDS  number of valid image words. The display address wraps
//                after IMAGE_WORDS-1, and host addresses at or above
//                IMAGE_WORDS read back as zero without touching the ROM.
//   ROM_LATENCY  cycles from registered rom_en/rom_addr to valid rom_data
//                (1..4)
//
// Ports:
//   clk_25M   pixel clock, the only clock
//   reset_n   synchronous active-low reset
//   bus       vga_rom_arbiter_if.slave: video timing, host handshake, ROM
//             and pixel signals (see the interface file)
//
// Timing summary:
//   active at N          -> rom_en at N+1 -> pix_valid at N+ROM_LATENCY+2
//   host_ack at N        -> host_rvalid at N+ROM_LATENCY+2
//   host_ack is combinational. Every other output is registered.
//
// Optional feature macro: ROM_ARB_STATS_EN adds bus.host_stall_cycles, a
// saturating count of cycles with host_req high and no ack. The count is
// cleared on frame_start and on reset.
// ---------------------------------------------------------------------------
module vga_rom_arbiter #(
  parameter int addrSize    = 16,
  parameter int dataWidth   = 12,
  parameter int IMAGE_WORDS = 40000,
  parameter int ROM_LATENCY = 1
) (
  input  logic                 clk_25M,
  input  logic                 reset_n,
  vga_rom_arbiter_if.slave     bus
);

  // Highest valid image address. It is the display wrap point and the
  // in-range limit for host reads.
  localparam logic [addrSize-1:0] LAST_ADDR = addrSize'(IMAGE_WORDS - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic                 active;

  logic [addrSize-1:0]  disp_addr_reg;
  logic [addrSize-1:0]  disp_addr_next;
  logic [addrSize-1:0]  disp_issue_addr;

  logic                 host_busy_reg;
  logic                 host_busy_next;
  logic                 host_grant;
  logic                 host_in_range;

  logic                 rom_en_reg;
  logic                 rom_en_next;
  logic [addrSize-1:0]  rom_addr_reg;
  logic [addrSize-1:0]  rom_addr_next;

  // Tag pipeline, one packed shift register per tag bit. Stage 0 is
  // registered together with rom_en. Stage ROM_LATENCY lines up with the
  // cycle in which rom_data is valid.
  //   disp  : pixel fetch
  //   host  : host read
  //   blank : host read of an out-of-range address. No ROM access was made,
  //           so zero is returned instead of rom_data.
  logic [ROM_LATENCY:0] tag_disp_reg;
  logic [ROM_LATENCY:0] tag_host_reg;
  logic [ROM_LATENCY:0] tag_blank_reg;
  logic                 tag_disp_next;
  logic                 tag_host_next;
  logic                 tag_blank_next;

  logic                 ret_disp;
  logic                 ret_host;
  logic                 ret_blank;

  logic [dataWidth-1:0] pix_data_reg;
  logic                 pix_valid_reg;
  logic [dataWidth-1:0] host_rdata_reg;
  logic                 host_rvalid_reg;

  assign active    = bus.enable_horizontal && bus.enable_vertical;

  assign ret_disp  = tag_disp_reg[ROM_LATENCY];
  assign ret_host  = tag_host_reg[ROM_LATENCY];
  assign ret_blank = tag_blank_reg[ROM_LATENCY];

  // -------------------------------------------------------------------------
  // Issue decision
  // -------------------------------------------------------------------------
  always_comb begin
    // The host is granted only outside active video and only when no host
    // read is in flight. Holding reset keeps the ack low.
    host_grant      = reset_n && !active && bus.host_req && !host_busy_reg;
    host_in_range   = (bus.host_addr <= LAST_ADDR);

    // frame_start restarts the display stream. If the same cycle is active,
    // address 0 is issued at once.
    disp_issue_addr = bus.frame_start ? '0 : disp_addr_reg;

    disp_addr_next  = disp_addr_reg;
    host_busy_next  = host_busy_reg;
    rom_en_next     = 1'b0;
    rom_addr_next   = rom_addr_reg;
    tag_disp_next   = 1'b0;
    tag_host_next   = 1'b0;
    tag_blank_next  = 1'b0;

    if (bus.frame_start) begin
      disp_addr_next = '0;
    end

    if (active) begin
      rom_en_next    = 1'b1;
      rom_addr_next  = disp_issue_addr;
      tag_disp_next  = 1'b1;
      disp_addr_next = (disp_issue_addr == LAST_ADDR) ? '0
                                                      : disp_issue_addr + 1'b1;
    end else if (host_grant) begin
      // An out-of-range read still travels through the tag pipeline, so
      // that its zero result arrives with the normal latency. It does not
      // strobe the ROM, and rom_addr keeps its last value.
      rom_en_next    = host_in_range;
      tag_host_next  = 1'b1;
      tag_blank_next = !host_in_range;
      if (host_in_range) begin
        rom_addr_next = bus.host_addr;
      end
    end

    // Busy drops on the edge that raises host_rvalid. That leaves the
    // rvalid cycle free to ack the next request, and a grant in that cycle
    // sets busy again.
    if (ret_host) begin
      host_busy_next = 1'b0;
    end
    if (host_grant) begin
      host_busy_next = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_25M) begin
    if (!reset_n) begin
      disp_addr_reg   <= '0;
      host_busy_reg   <= 1'b0;
      rom_en_reg      <= 1'b0;
      rom_addr_reg    <= '0;
      tag_disp_reg    <= '0;
      tag_host_reg    <= '0;
      tag_blank_reg   <= '0;
      pix_data_reg    <= '0;
      pix_valid_reg   <= 1'b0;
      host_rdata_reg  <= '0;
      host_rvalid_reg <= 1'b0;
    end else begin
      disp_addr_reg   <= disp_addr_next;
      host_busy_reg   <= host_busy_next;
      rom_en_reg      <= rom_en_next;
      rom_addr_reg    <= rom_addr_next;
      tag_disp_reg    <= {tag_disp_reg[ROM_LATENCY-1:0],  tag_disp_next};
      tag_host_reg    <= {tag_host_reg[ROM_LATENCY-1:0],  tag_host_next};
      tag_blank_reg   <= {tag_blank_reg[ROM_LATENCY-1:0], tag_blank_next};

      // Only the output whose tag matches is updated. The other one holds
      // its data, and its valid stays low.
      pix_valid_reg   <= ret_disp;
      host_rvalid_reg <= ret_host;
      if (ret_disp) begin
        pix_data_reg <= bus.rom_data;
      end
      if (ret_host) begin
        host_rdata_reg <= ret_blank ? '0 : bus.rom_data;
      end
    end
  end

  assign bus.host_ack    = host_grant;
  assign bus.rom_en      = rom_en_reg;
  assign bus.rom_addr    = rom_addr_reg;
  assign bus.pix_data    = pix_data_reg;
  assign bus.pix_valid   = pix_valid_reg;
  assign bus.host_rdata  = host_rdata_reg;
  assign bus.host_rvalid = host_rvalid_reg;

  // -------------------------------------------------------------------------
  // Optional host stall statistics
  // -------------------------------------------------------------------------
`ifdef ROM_ARB_STATS_EN
  logic [15:0] stall_cnt_reg;
  logic [15:0] stall_cnt_next;

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (bus.frame_start) begin
      stall_cnt_next = '0;
    end else if (bus.host_req && !host_grant && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_next = stall_cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge clk_25M) begin
    if (!reset_n) begin
      stall_cnt_reg <= '0;
    end else begin
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  assign bus.host_stall_cycles = stall_cnt_reg;
`endif

endmodule

// File: doc/vga_rom_arbiter.md
# vga_rom_arbiter

Shares the single-port image ROM between the VGA pixel fetch path and a host read port. Display fetches get absolute priority during active video (enable_horizontal && enable_vertical). Host reads are serviced in blanking or other idle cycles. The block owns the display address counter and tags every in-flight ROM read so that returned data is steered to the correct requester after the ROM latency.

## Interface
- addrSize, 16, ROM address width
- dataWidth, 12, ROM word width (RGB444)
- IMAGE_WORDS, 40000, number of valid image words; display address wraps at IMAGE_WORDS-1
- ROM_LATENCY, 1, cycles from rom_en/rom_addr registered to rom_data valid (1..4)

- clk_25M  in  1  pixel clock; only clock
- reset_n  in  1  synchronous, active-low reset
- enable_horizontal  in  1  horizontal active-video window
- enable_vertical  in  1  vertical active-video window
- frame_start  in  1  one-cycle pulse at start of frame; restarts display address
- host_req  in  1  host read request; held high until host_ack
- host_addr  in  addrSize  host read address; sampled on the ack cycle
- host_ack  out  1  one-cycle pulse: request accepted
- host_rdata  out  dataWidth  host read data
- host_rvalid  out  1  one-cycle pulse: host_rdata valid
- rom_en  out  1  ROM read strobe
- rom_addr  out  addrSize  ROM address
- rom_data  in  dataWidth  ROM read data
- pix_data  out  dataWidth  pixel word to the colour output
- pix_valid  out  1  pix_data valid

## Operation
- active = enable_horizontal && enable_vertical, sampled at cycle N.
- Issue decision at cycle N, registered into rom_en/rom_addr/tag at N+1:
  - active: display grant. rom_addr = disp_addr. disp_addr increments; it wraps from IMAGE_WORDS-1 to 0.
  - !active && host_req && !host_busy: host grant. host_ack=1 at N. host_addr is captured. host_busy is set.
  - otherwise: rom_en=0, rom_addr holds its last value.
- frame_start at N forces disp_addr to 0. If active is also high at N, address 0 is issued and the next address is 1. Otherwise the next active cycle issues 0.
- Only one host read is outstanding at a time. host_busy clears on the host_rvalid cycle, and a new ack is possible in that same cycle.
- A host_addr >= IMAGE_WORDS is acked but does not drive rom_en. host_rdata=0 is returned with the normal latency.
- Tag pipeline: a ROM_LATENCY+1 deep shift register of {disp, host} bits. When rom_data returns, it is registered into pix_data (disp tag) or host_rdata (host tag). The other output holds its value, and only the matching valid pulses.
- Host requests are never granted during active video. They wait, with no timeout.

## Timing
- Display: active at N, then pix_valid at N+ROM_LATENCY+2. One pixel per active cycle, no bubbles.
- Host: ack at N, then host_rvalid at N+ROM_LATENCY+2.
- host_ack is combinational from host_req, active and host_busy. All other outputs are registered.
- Reset (reset_n=0 at a clock edge) clears host_ack, host_rvalid, pix_valid, rom_en, rom_addr, pix_data, host_rdata, disp_addr, host_busy and the tag pipeline to 0.
- Reset mid-read discards in-flight data, and no valid pulse follows.
- Reset has priority over frame_start and over grants.

## Configuration
- ROM_ARB_STATS_EN defined:
  - Adds output host_stall_cycles [15:0]: the count of cycles with host_req=1 and host_ack=0.
  - The count saturates at 16'hFFFF, is cleared on frame_start and on reset, and is registered.
- ROM_ARB_STATS_EN undefined: the port and the counter are absent. Arbitration behaviour is identical.

## Test plan
- Reset: hold reset_n=0 for 3 cycles with host_req=1 and active=1 → all outputs 0 and no host_ack. After release, the first active cycle issues rom_addr=0.
- Display streaming, ROM_LATENCY=1: frame_start plus 640 active cycles → rom_addr 0..639 contiguous. pix_valid rises 3 cycles after the first active cycle, and pix_data matches the ROM model.
- Wrap: preload disp_addr to 39998 via 39998 active cycles, then 3 more → addresses 39998, 39999, 0.
- Host during active video: host_req=1, host_addr=16'h0100 through 10 active cycles and then blanking → no ack during active. Ack on the first blanking cycle, host_rvalid 3 cycles later with the word at 0x100. With ROM_ARB_STATS_EN, host_stall_cycles=10.
- Back-to-back host reads in blanking, ROM_LATENCY=2 → acks spaced 4 cycles apart. The second ack coincides with the first host_rvalid.
- Out-of-range and reset mid-flight: host_addr=40000 → ack with rom_en=0 and host_rdata=0 valid 3 cycles later. Reset 1 cycle after a display issue → no pix_valid pulse.
